// File: rtl/paicore_rx_packer_if.sv
// AXI-Stream bundle (data, valid, last, ready) shared by the packer input and output sides.
// Latency: none, wires only.
// Backpressure: ready travels from the slave modport back to the master modport.
interface paicore_rx_packer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/paicore_rx_packer.sv
// Holds the newest input beat so tlast can be applied late; closes packets on tlast, beat limit, idle timeout or disable.
// Latency: 2 cycles from accept to output; a closed beat leaves 1 cycle after the output register frees.
// Backpressure: s_axis tready drops while flushing, or when both registers are full and m_axis is stalled.
module paicore_rx_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic [CNT_WIDTH-1:0] oFrameNumMax,
    input  logic [CNT_WIDTH-1:0] idle_timeout,
    paicore_rx_packer_if.slave   s_axis,
    paicore_rx_packer_if.master  m_axis,
    output logic                 o_pkt_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_pkt_cnt,
    output logic [CNT_WIDTH-1:0] o_beat_cnt
);
    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] h_dat;
    logic                  h_vld;
    logic [DATA_WIDTH-1:0] o_dat;
    logic                  o_vld;
    logic                  o_last;
    logic [CNT_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]  idle_cnt;

    logic                  o_free;
    logic                  s_rdy;
    logic                  s_acc;
    logic                  m_hs;
    logic [CNT_WIDTH-1:0]  idx_nxt;
    logic                  close_beat;
    logic                  timeout_hit;

    assign o_free      = !o_vld || m_axis.tready;
    assign s_rdy       = !rst && i_enable && (state != FLUSH) && (!h_vld || o_free);
    assign s_acc       = s_axis.tvalid && s_rdy;
    assign m_hs        = o_vld && m_axis.tready;
    assign idx_nxt     = (state == HOLD) ? idx + 1'b1 : CNT_WIDTH'(1);
    // >= rather than == so a limit lowered below the running index closes on the next beat.
    assign close_beat  = s_axis.tlast || ((oFrameNumMax != '0) && (idx_nxt >= oFrameNumMax));
    // Fires on the cycle whose increment would make the idle count equal the timeout.
    assign timeout_hit = (idle_timeout != '0) && (idle_cnt >= idle_timeout - 1'b1);

    assign s_axis.tready = s_rdy;
    assign m_axis.tdata  = o_dat;
    assign m_axis.tvalid = o_vld;
    assign m_axis.tlast  = o_last;
    assign o_pkt_done    = !rst && m_hs && o_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_dat      <= '0;
            h_vld      <= 1'b0;
            o_dat      <= '0;
            o_vld      <= 1'b0;
            o_last     <= 1'b0;
            idx        <= '0;
            idle_cnt   <= '0;
            o_timeout  <= 1'b0;
            o_pkt_cnt  <= '0;
            o_beat_cnt <= '0;
        end else begin
            if (m_hs) begin
                o_vld      <= 1'b0;
                o_beat_cnt <= o_beat_cnt + 1'b1;
                if (o_last) begin
                    o_pkt_cnt <= o_pkt_cnt + 1'b1;
                end
            end
            case (state)
                IDLE, HOLD: begin
                    if (s_acc) begin
                        if (state == HOLD) begin
                            o_vld  <= 1'b1;
                            o_dat  <= h_dat;
                            o_last <= 1'b0;
                        end
                        h_dat     <= s_axis.tdata;
                        h_vld     <= 1'b1;
                        idle_cnt  <= '0;
                        o_timeout <= 1'b0;
                        if (close_beat) begin
                            idx   <= '0;
                            state <= FLUSH;
                        end else begin
                            idx   <= idx_nxt;
                            state <= HOLD;
                        end
                    end else if (state == HOLD) begin
                        if (!i_enable) begin
                            state <= FLUSH;
                        end else if (timeout_hit) begin
                            state     <= FLUSH;
                            o_timeout <= 1'b1;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (o_free) begin
                        o_vld    <= 1'b1;
                        o_dat    <= h_dat;
                        o_last   <= 1'b1;
                        h_vld    <= 1'b0;
                        idx      <= '0;
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
